// File: rtl/speculative_history_register.sv
// rtl/speculative_history_register.sv - speculative/committed branch history with checkpointed recovery
// Optional feature: SPEC_HIST_FOLD_EN adds the folded_history output.
module speculative_history_register #(
  parameter int HISTORY_LENGTH = 32,
  parameter int CKPT_DEPTH     = 8,
  parameter int FOLD_LENGTH    = 8,
  localparam int PTR_W         = $clog2(CKPT_DEPTH),
  localparam int CNT_W         = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pred_valid,
  input  logic                      pred_taken,
  output logic                      pred_ready,
  output logic [PTR_W-1:0]          pred_tag,
  input  logic                      resolve_valid,
  input  logic [PTR_W-1:0]          resolve_tag,
  input  logic                      resolve_taken,
  input  logic                      retire_valid,
  input  logic                      retire_taken,
  output logic [HISTORY_LENGTH-1:0] spec_history,
  output logic [HISTORY_LENGTH-1:0] arch_history,
  output logic [CNT_W-1:0]          ckpt_count,
  output logic                      err
`ifdef SPEC_HIST_FOLD_EN
  ,
  output logic [FOLD_LENGTH-1:0]    folded_history
`endif
);

  logic [HISTORY_LENGTH-1:0] ckpt [CKPT_DEPTH];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;

  logic [PTR_W-1:0] res_off;
  logic             res_in_flight;
  logic             pred_acc;
  logic             retire_ok;
  logic             resolve_ok;
  logic             bad_req;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

  assign pred_ready = (ckpt_count < CNT_W'(CKPT_DEPTH)) && !resolve_valid;
  assign pred_tag   = tail;

  // A tag is in flight when its distance from head is below the occupancy.
  assign res_off       = resolve_tag - head;
  assign res_in_flight = {1'b0, res_off} < ckpt_count;

  assign pred_acc   = pred_valid && pred_ready;
  assign retire_ok  = retire_valid && (ckpt_count != '0);
  assign resolve_ok = resolve_valid && res_in_flight;
  assign bad_req    = (retire_valid && (ckpt_count == '0)) ||
                      (resolve_valid && !res_in_flight);

  // Resolve truncates the buffer just past the resolved entry; retire then removes head.
  always_comb begin
    cnt_base = '0;
    if (resolve_ok) begin
      cnt_base = {1'b0, res_off} + CNT_W'(1);
    end else begin
      cnt_base = ckpt_count + CNT_W'(pred_acc);
    end
    cnt_next = cnt_base - CNT_W'(retire_ok);
  end

  always_ff @(posedge clk) begin
    if (pred_acc) begin
      ckpt[tail] <= spec_history;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_history <= '0;
      arch_history <= '0;
      head         <= '0;
      tail         <= '0;
      ckpt_count   <= '0;
      err          <= 1'b0;
    end else begin
      if (resolve_ok) begin
        spec_history <= {ckpt[resolve_tag][HISTORY_LENGTH-2:0], resolve_taken};
        tail         <= resolve_tag + PTR_W'(1);
      end else if (pred_acc) begin
        spec_history <= {spec_history[HISTORY_LENGTH-2:0], pred_taken};
        tail         <= tail + PTR_W'(1);
      end
      if (retire_ok) begin
        arch_history <= {arch_history[HISTORY_LENGTH-2:0], retire_taken};
        head         <= head + PTR_W'(1);
      end
      ckpt_count <= cnt_next;
      err        <= err | bad_req;
    end
  end

`ifdef SPEC_HIST_FOLD_EN
  logic [FOLD_LENGTH-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < HISTORY_LENGTH / FOLD_LENGTH; i++) begin
      fold = fold ^ spec_history[i*FOLD_LENGTH +: FOLD_LENGTH];
    end
  end

  assign folded_history = fold;
`endif

endmodule

// File: tb/tb_speculative_history_register.sv
// tb/tb_speculative_history_register.sv - directed and random checks against a queue-based model
module tb_speculative_history_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, pred_ready;
  logic [1:0] pred_tag;
  logic       resolve_valid, resolve_taken;
  logic [1:0] resolve_tag;
  logic       retire_valid, retire_taken;
  logic [7:0] spec_history, arch_history;
  logic [2:0] ckpt_count;
  logic       err;
`ifdef SPEC_HIST_FOLD_EN
  logic [3:0] folded_history;
`endif

  speculative_history_register #(
    .HISTORY_LENGTH(8),
    .CKPT_DEPTH(4),
    .FOLD_LENGTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .pred_tag(pred_tag),
    .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken),
    .retire_valid(retire_valid),
    .retire_taken(retire_taken),
    .spec_history(spec_history),
    .arch_history(arch_history),
    .ckpt_count(ckpt_count),
    .err(err)
`ifdef SPEC_HIST_FOLD_EN
    ,
    .folded_history(folded_history)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tag;
    logic [7:0] hist;
  } ck_t;

  ck_t        q[$];
  logic [7:0] m_spec, m_arch;
  logic [1:0] m_tail;
  logic       m_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_spec"}, 32'(spec_history), 32'(m_spec));
    chk({tag, "_arch"}, 32'(arch_history), 32'(m_arch));
    chk({tag, "_count"}, 32'(ckpt_count), 32'(q.size()));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic model_clear();
    q.delete();
    m_spec = 8'h00;
    m_arch = 8'h00;
    m_tail = 2'd0;
    m_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    pred_valid = 0; pred_taken = 0;
    resolve_valid = 0; resolve_tag = 0; resolve_taken = 0;
    retire_valid = 0; retire_taken = 0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and expects outputs to clear at once.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    model_clear();
    chk_regs("rst");
    chk("rst_tag", 32'(pred_tag), 32'd0);
    chk("rst_ready", 32'(pred_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; model follows the behavioural rules on the queue of in-flight branches.
  task automatic cyc(input logic pv, input logic pt, input logic rv, input logic [1:0] rtag,
                     input logic rt, input logic retv, input logic rett);
    logic ready, retire_ok;
    int   idx;
    pred_valid = pv; pred_taken = pt;
    resolve_valid = rv; resolve_tag = rtag; resolve_taken = rt;
    retire_valid = retv; retire_taken = rett;
    ready = (q.size() < 4) && !rv;
    #1;
    chk("ready", 32'(pred_ready), 32'(ready));
    chk("tag", 32'(pred_tag), 32'(m_tail));
    idx = -1;
    foreach (q[i]) if (q[i].tag == rtag) idx = i;
    retire_ok = retv && (q.size() > 0);
    if ((rv && idx < 0) || (retv && q.size() == 0)) m_err = 1'b1;
    if (rv && idx >= 0) begin
      m_spec = {q[idx].hist[6:0], rt};
      while (q.size() > idx + 1) void'(q.pop_back());
      m_tail = rtag + 2'd1;
    end else if (pv && ready) begin
      q.push_back('{tag: m_tail, hist: m_spec});
      m_spec = {m_spec[6:0], pt};
      m_tail = m_tail + 2'd1;
    end
    if (retire_ok) begin
      m_arch = {m_arch[6:0], rett};
      void'(q.pop_front());
    end
    @(posedge clk); #1;
    chk_regs("cyc");
  endtask

  task automatic pred(input logic t);
    cyc(1, t, 0, 2'd0, 0, 0, 0);
  endtask

  logic [7:0] saved;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #2;
    chk_regs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Taken, not, taken from reset
    chk("r34_tag0", 32'(pred_tag), 32'd0);
    pred(1);
    chk("r34_tag1", 32'(pred_tag), 32'd1);
    pred(0);
    chk("r34_tag2", 32'(pred_tag), 32'd2);
    pred(1);
    chk("r34_spec", 32'(spec_history), 32'h05);
    chk("r34_cnt", 32'(ckpt_count), 32'd3);
    chk("r34_arch", 32'(arch_history), 32'h00);

    // Full buffer rejects a fifth prediction
    pred(1);
    saved = spec_history;
    chk("r35_full_ready", 32'(pred_ready), 32'd0);
    pred(0);
    chk("r35_cnt", 32'(ckpt_count), 32'd4);
    chk("r35_spec", 32'(spec_history), 32'(saved));

    // Mispredict recovery on tag 1
    do_reset();
    pred(1); pred(1); pred(1);
    chk("r36_spec7", 32'(spec_history), 32'h07);
    cyc(0, 0, 1, 2'd1, 0, 0, 0);
    chk("r36_spec", 32'(spec_history), 32'h02);
    chk("r36_cnt", 32'(ckpt_count), 32'd2);
    chk("r36_tag", 32'(pred_tag), 32'd2);

    // Retire when empty is sticky
    do_reset();
    cyc(0, 0, 0, 2'd0, 0, 1, 1);
    chk("r37_err", 32'(err), 32'd1);
    chk("r37_arch", 32'(arch_history), 32'h00);
    pred(1); cyc(0, 0, 0, 2'd0, 0, 1, 0);
    chk("r37_sticky", 32'(err), 32'd1);
    cyc(0, 0, 1, 2'd3, 1, 0, 0);
    chk("r37_bad_res_cnt", 32'(ckpt_count), 32'd0);

    // Tail wrap, then same-cycle retire and resolve of head
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pred(i[0]);
      cyc(0, 0, 0, 2'd0, 0, 1, i[1]);
    end
    chk("r38_wrap_tag", 32'(pred_tag), 32'd0);
    pred(0);
    saved = spec_history;
    cyc(0, 0, 1, 2'd0, 1, 1, 1);
    chk("r38_cnt", 32'(ckpt_count), 32'd0);
    chk("r38_spec", 32'(spec_history), 32'({saved[7:1], 1'b1}));
    chk("r38_err", 32'(err), 32'd0);

    // Build 8'hA5, retiring alongside to keep room
    do_reset();
    pred(1);
    for (int i = 1; i < 8; i++) cyc(1, (8'hA5 >> (7 - i)) & 1'b1, 0, 2'd0, 0, 1, 1);
    chk("r39_spec", 32'(spec_history), 32'hA5);
`ifdef SPEC_HIST_FOLD_EN
    chk("r39_fold", 32'(folded_history), 32'hF);
`endif
    do_reset();

    // Randomized traffic with periodic resets
    for (int n = 0; n < 400; n++) begin
      logic       pv, rv, retv;
      logic [1:0] rtag;
      if (n % 80 == 79) begin
        do_reset();
        continue;
      end
      pv   = ($urandom_range(0, 9) < 6);
      rv   = ($urandom_range(0, 9) < 2);
      rtag = 2'($urandom_range(0, 3));
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        rtag = q[$urandom_range(0, q.size() - 1)].tag;
      retv = (q.size() > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      cyc(pv, 1'($urandom), rv, rtag, 1'($urandom), retv, 1'($urandom));
`ifdef SPEC_HIST_FOLD_EN
      chk("rnd_fold", 32'(folded_history), 32'(m_spec[7:4] ^ m_spec[3:0]));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/speculative_history_register.md
SPECULATIVE_HISTORY_REGISTER -- requirements
Module: speculative_history_register

Interface
REQ-001 SHALL have parameter HISTORY_LENGTH, default 32, history bits held (minimum 2).
REQ-002 SHALL have parameter CKPT_DEPTH, default 8, in-flight branch checkpoints (power of 2, minimum 2).
REQ-003 SHALL have parameter FOLD_LENGTH, default 8, folded-history width (divides HISTORY_LENGTH).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pred_valid  input  1  new predicted branch.
REQ-007 SHALL have port pred_taken  input  1  predicted direction.
REQ-008 SHALL have port pred_ready  output  1  checkpoint slot available.
REQ-009 SHALL have port pred_tag  output  log2(CKPT_DEPTH)  tag allocated to the accepted prediction.
REQ-010 SHALL have port resolve_valid  input  1  branch resolved mispredicted.
REQ-011 SHALL have port resolve_tag  input  log2(CKPT_DEPTH)  tag of the mispredicted branch.
REQ-012 SHALL have port resolve_taken  input  1  actual outcome.
REQ-013 SHALL have port retire_valid  input  1  oldest in-flight branch retires.
REQ-014 SHALL have port retire_taken  input  1  retired outcome.
REQ-015 SHALL have port spec_history  output  HISTORY_LENGTH  speculative history.
REQ-016 SHALL have port arch_history  output  HISTORY_LENGTH  committed history.
REQ-017 SHALL have port ckpt_count  output  log2(CKPT_DEPTH)+1  in-flight count.
REQ-018 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-019 SHALL hold checkpoints in a circular buffer with head (oldest) and tail pointers, program order.
REQ-020 SHALL drive pred_ready = (ckpt_count < CKPT_DEPTH) and not resolve_valid, combinationally.
REQ-021 SHALL drive pred_tag = tail pointer, combinationally.
REQ-022 SHALL, on pred_valid and pred_ready, store pre-shift spec_history at the tail slot, advance tail, set spec_history <= {spec_history[HISTORY_LENGTH-2:0], pred_taken}; one-cycle latency.
REQ-023 SHALL ignore pred_valid when pred_ready is low, leaving all state unchanged.
REQ-024 SHALL, on resolve_valid with an in-flight tag, set spec_history <= {ckpt[resolve_tag][HISTORY_LENGTH-2:0], resolve_taken}, tail <= resolve_tag+1 (mod CKPT_DEPTH), flushing younger checkpoints; the resolved entry stays in flight.
REQ-025 SHALL, on retire_valid with ckpt_count > 0, set arch_history <= {arch_history[HISTORY_LENGTH-2:0], retire_taken} and advance head.
REQ-026 SHALL accept retire and resolve in the same cycle; pointer and count updates compose, including when resolve_tag equals head (spec restore applies, head entry retires).
REQ-027 SHALL set err on retire_valid with ckpt_count = 0, or on resolve_valid with a tag not in flight; the offending request is otherwise ignored.
REQ-028 SHALL wrap head and tail modulo CKPT_DEPTH; ckpt_count distinguishes full (CKPT_DEPTH) from empty (0).
REQ-029 SHALL register all outputs except pred_ready and pred_tag.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear spec_history, arch_history, head, tail, ckpt_count and err to 0; checkpoint storage need not reset.
REQ-031 SHALL discard all in-flight checkpoints on reset mid-operation; first accepted prediction after release gets pred_tag 0.

Configuration
REQ-032 SHALL, with SPEC_HIST_FOLD_EN defined, add output folded_history [FOLD_LENGTH-1:0] = XOR of the HISTORY_LENGTH/FOLD_LENGTH consecutive FOLD_LENGTH-bit slices of spec_history, combinational from the register.
REQ-033 SHALL, without SPEC_HIST_FOLD_EN, omit folded_history port and logic entirely; all other behaviour unchanged.

Verification (HISTORY_LENGTH=8, CKPT_DEPTH=4)
REQ-034 SHALL cover: predict taken, not, taken from reset -> spec_history=8'h05, tags 0,1,2, ckpt_count=3, arch_history=8'h00.
REQ-035 SHALL cover: 4 predictions then 5th pred_valid -> pred_ready=0, 5th ignored, ckpt_count=4, spec_history unchanged.
REQ-036 SHALL cover: predictions T,T,T (spec 8'h07), resolve tag 1 taken=0 -> spec_history=8'h02, ckpt_count=2, next pred_tag=2.
REQ-037 SHALL cover: retire with ckpt_count=0 -> err=1, arch_history unchanged; err stays 1 until rst_n low.
REQ-038 SHALL cover: tail wrap — 4 predict/retire pairs then predict -> pred_tag=0; same-cycle retire head and resolve head -> ckpt_count=0, spec restored.
REQ-039 SHALL cover: SPEC_HIST_FOLD_EN with FOLD_LENGTH=4, spec_history=8'hA5 -> folded_history=4'hF; rst_n low mid-stream -> all outputs 0 immediately.
